// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x4 router. Each entry carries a header tag,
// used on the read side to track the remaining packet length and zero data_out between packets.
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = 7;

  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               lfd_q, lfd_d;
  logic               wr_en, rd_en;
  logic [WIDTH:0]     rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign wr_en    = write_enb && !full;
  assign rd_en    = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    // lfd_state is delayed one clock so the tag lines up with router_reg's dout
    lfd_d      = lfd_state;

    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        data_out_d = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // header length field plus the trailing parity byte
          count_d = CNT_W'(rd_entry[WIDTH-1:2]) + CNT_W'(1);
        end else if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end
      end else if (count_q == '0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      lfd_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      lfd_q      <= lfd_d;
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !soft_reset) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_q, data_in};
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Randomized and directed bench for router_fifo against a queue-based packet model.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a queue of {tag, byte}, the remaining packet count and the output byte.
  logic [8:0] mq[$];
  logic       m_lfd;
  int         m_cnt;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".dout"},  32'(data_out), 32'(m_dout));
    chk({tag, ".full"},  32'(full),     32'(mq.size() == 16));
    chk({tag, ".empty"}, 32'(empty),    32'(mq.size() == 0));
  endtask

  task automatic model_clear(input bit hard);
    mq.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    if (hard) m_lfd = 1'b0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check #1 later.
  task automatic cyc(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                     input bit sr, input string tag);
    bit         was_full, was_empty;
    logic [8:0] e;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    @(posedge clk);
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    if (sr) begin
      model_clear(1'b0);
    end else begin
      if (re && !was_empty) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8])           m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (we && !was_full) mq.push_back({m_lfd, din});
    end
    m_lfd = lfd;
    #1;
    check_outs(tag);
  endtask

  task automatic mid_reset();
    #2 resetn = 1'b0;
    model_clear(1'b1);
    #1 check_outs("async_rst");
    @(posedge clk);
    #1 resetn = 1'b1;
    check_outs("rst_release");
  endtask

  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] hdr, par, b;
    hdr = {len, addr};
    par = hdr;
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "lfd");
    cyc(1'b1, 1'b0, 1'b0, hdr, 1'b0, "wr_hdr");
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      par = par ^ b;
      cyc(1'b1, 1'b0, 1'b0, b, 1'b0, "wr_pay");
    end
    cyc(1'b1, 1'b0, 1'b0, par, 1'b0, "wr_par");
  endtask

  task automatic reads(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic idles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, tag);
  endtask

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    model_clear(1'b1);
    #1 check_outs("init_rst");
    @(posedge clk);
    #1 resetn = 1'b1;

    // single packet: header 0x22, 8 payload bytes, parity
    send_pkt(6'd8, 2'd2);
    reads(1, "pkt_hdr");
    idles(2, "pkt_hold");
    reads(9, "pkt_body");
    idles(2, "pkt_idle");

    // async reset while data_out holds a mid-packet byte
    send_pkt(6'd4, 2'd1);
    reads(2, "pre_rst");
    mid_reset();
    idles(1, "post_rst");

    // fill to full, overflow write, drain
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, "fill");
    reads(1, "fill_rd1");
    reads(16, "fill_drain");
    idles(1, "fill_idle");

    // preload 8 then simultaneous read/write across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, "pre8");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, "rw_wrap");
    reads(9, "wrap_drain");

    // flush in the middle of a packet read with a concurrent write
    send_pkt(6'd5, 2'd0);
    reads(3, "pre_flush");
    cyc(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, "flush");
    idles(1, "post_flush");
    send_pkt(6'd3, 2'd3);
    reads(5, "after_flush");
    idles(1, "after_flush_idle");

    // over-read on empty
    reads(3, "over_rd");
    cyc(1'b1, 1'b0, 1'b0, 8'h5C, 1'b0, "over_wr");
    reads(1, "over_rd_back");
    idles(1, "over_idle");

    // random traffic with occasional flushes and header tags
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 8'($urandom),
          ($urandom_range(0, 40) == 0), "rand");
      if (i == 200) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-destination output FIFO of the 1x4 router, directly downstream of router_reg. Four instances exist, one per output port.
- Each instance buffers the byte stream router_reg drives on dout: header, payload, then parity.
- Each entry is tagged with a header flag. The read side uses the tag to track packet length and idle the output between packets.
- full feeds back to the router FSM via the synchronizer; soft_reset comes from the synchronizer's read-timeout logic.

Parameters:
WIDTH, 8, data byte width
DEPTH, 16, number of entries (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous flush from synchronizer timeout, active high
write_enb  input  1  write request (decoded by synchronizer for this port)
read_enb  input  1  read request from destination client
lfd_state  input  1  FSM load-first-data state, marks header byte
data_in  input  WIDTH  byte from router_reg dout
data_out  output  WIDTH  registered read data
full  output  1  no free entry
empty  output  1  no stored entry

Behaviour:
Storage:
- Array of DEPTH x (WIDTH+1) bits. Bit WIDTH is the header tag.
- Tag written = lfd_q, where lfd_q is lfd_state registered one clock. This aligns the tag with router_reg's one-cycle dout latency.

Pointers:
- wr_ptr and rd_ptr are ADDR_W+1 bits and wrap naturally modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ and low ADDR_W bits equal).
- full and empty are combinational from the pointers.

Write:
- Occurs when write_enb && !full. Stores {lfd_q, data_in} at wr_ptr[ADDR_W-1:0], then wr_ptr+1.
- Write while full is dropped silently; the pointer is unchanged.

Read:
- Occurs when read_enb && !empty. data_out <= mem[rd_ptr][WIDTH-1:0], then rd_ptr+1.
- Read while empty is ignored.

Simultaneous read and write:
- Both proceed independently, each evaluated against the pre-edge full/empty.
- When full, the read proceeds and the write is dropped.
- When empty, the write proceeds and the read is ignored. No same-cycle bypass.

Packet counter (7 bits):
- On a read of a tagged entry: count <= mem[7:2] + 1 (payload length plus parity byte).
- On a read of an untagged entry with count != 0: count <= count - 1.
- count never underflows.

data_out idle rule:
- No read this cycle and count == 0: data_out <= 8'h00.
- No read this cycle and count != 0: data_out holds its value.

Latency:
- data_out is valid the cycle after the read_enb edge.
- A written byte is readable the cycle after the write edge.

Reset and flush:
- resetn low, asynchronous and immediate: wr_ptr, rd_ptr, count, lfd_q, data_out = 0; empty=1, full=0. Array contents are not cleared.
- soft_reset high at an edge: same clears as resetn, except lfd_q is unaffected. A write or read in the same cycle is ignored.
- Priority: resetn > soft_reset > read/write.
- Reset or flush mid-packet discards remaining entries. A following packet starts clean with no stale tag or count.

Test Plan:
1. Reset: pulse resetn low between clock edges -> data_out=0x00, empty=1, full=0 immediately, before the next edge.
2. Single packet, lfd_state one cycle before header 0x22 (len 8, addr 2), 8 payload bytes, parity -> 10 entries. Then 10 read cycles:
   - data_out reproduces the written order one cycle after each read.
   - count goes 9 down to 0.
   - data_out = 0x00 on the first idle cycle after the last read.
3. Fill: 16 writes -> full=1 after the 16th. 17th write dropped. One read returns the first byte, full=0. Remaining reads match the first 16 bytes.
4. Concurrency and wrap: preload 8 bytes, then 20 cycles of simultaneous read/write.
   - Occupancy stays 8; full and empty never assert.
   - Output order is correct across pointer wrap.
5. Flush: assert soft_reset during the payload read of a packet with write_enb high -> next cycle empty=1, data_out=0x00, count=0, same-cycle write absent. A new packet afterwards reads back correctly.
6. Over-read: read_enb held high on an empty FIFO for 3 cycles -> rd_ptr unchanged, data_out stays 0x00, empty remains 1.
